pp_reduce_seq: RTL and testbench
================================

Name: pp_reduce_seq

Overview:
Consumer end of the 6x6 partial-product interface. It accepts one flattened partial-product matrix per transaction over a valid/ready handshake. It reduces the matrix row by row with shift-add, one row per clock, into a 2N-bit product. A configurable number of LSB columns can be truncated for approximate operation. It sits downstream of the partial-product generator and drives the multiplier result register or the next pipeline stage.

Parameters:
N, 6, operand width; the matrix is N x N bits and the product is 2N bits.
APPROX_COLS, 0, number of LSB columns (weight 2^0 .. 2^(APPROX_COLS-1)) dropped; legal range 0..2N; 0 gives an exact product.

Ports:
clk  input  1  single clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
pp_in  input  N*N  partial-product matrix; bit i*N+j = x[j] & y[i], so row i is weighted 2^i and bit j of a row is weighted 2^j.
in_valid  input  1  pp_in is valid.
in_ready  output  1  block can accept a matrix.
prod  output  2N  reduced product.
out_valid  output  1  prod is valid.
out_ready  input  1  downstream accepts prod.
busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; internal matrix register, accumulator and row counter cleared to 0.
  - prod = 0, out_valid = 0, busy = 0, in_ready = 1.
- Outputs are decoded from state: in_ready = (state == IDLE), out_valid = (state == DONE), busy = (state != IDLE).
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - On an edge with in_valid = 1, capture pp_in, clear the accumulator, set cnt = 0 and go to ACCUM.
  - With in_valid = 0, remain in IDLE.
- ACCUM:
  - Each edge computes acc <= acc + ((row[cnt] & mask(cnt)) << cnt), then cnt <= cnt + 1.
  - mask(cnt) bit j = 1 if and only if (cnt + j) >= APPROX_COLS.
  - After the edge that processes row N-1, load prod <= final accumulator value and go to DONE.
  - The counter width is $clog2(N)+1; there is no wrap-around, and the counter is cleared on entry to ACCUM.
- DONE:
  - prod is held stable until a handshake edge (out_valid = 1 and out_ready = 1), which returns the FSM to IDLE.
  - Without out_ready, the FSM stays in DONE indefinitely (backpressure).
- Latency: accept edge T, rows processed at edges T+1 .. T+N, out_valid = 1 after edge T+N. For N = 6 this is 6 cycles from accept to out_valid.
- Throughput: one transaction per N+2 cycles minimum. in_ready is 0 in ACCUM and DONE, so in_valid in those states is ignored and pp_in is not sampled. No same-edge output-accept/input-accept overlap.
- Width: the accumulator is 2N bits. The maximum exact sum (2^N - 1)^2 fits, so there is no overflow and no saturation logic.
- prod keeps its last value after returning to IDLE; only reset clears it.
- A reset asserted in ACCUM or DONE aborts the transaction: no out_valid pulse, and prod = 0.
- APPROX_COLS >= 2N gives prod = 0 for every input.

Test Plan:
- Exact reduction, APPROX_COLS=0: x=1, y=3 matrix, single in_valid pulse -> in_ready drops the next cycle; out_valid rises 6 cycles after the accept edge with prod = 12'd3.
- Maximum operands, APPROX_COLS=0: x=63, y=63 (all-ones matrix) -> prod = 12'd3969; x=0, y=0 -> prod = 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> prod and out_valid stable and in_ready=0. Then raise out_ready for one cycle -> next cycle out_valid=0 and in_ready=1.
- Approximate mode, APPROX_COLS=3: x=7, y=7 -> prod = 12'd32 (49 minus 17 truncated). x=63, y=63 -> prod = 3969 - 17 = 12'd3952.
- Busy input ignored: send x=5, y=9, then drive in_valid with x=2, y=2 during ACCUM -> prod = 45 and only one out_valid pulse. A follow-up x=2, y=2 sent after return to IDLE -> prod = 4.
- Reset mid-operation: assert rst 3 cycles after accept -> out_valid=0, prod=0 and in_ready=1 immediately (asynchronous). No stale result appears after rst is released.

Source files
------------

// File: rtl/pp_reduce_seq_if.sv
// Valid/ready bundle between the partial-product generator, the reducer
// and the downstream result consumer.
interface pp_reduce_seq_if #(
  parameter int N = 6
);
  logic [N*N-1:0] pp_in;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] prod;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output pp_in, in_valid, out_ready,
    input  in_ready, prod, out_valid
  );

  modport slave (
    input  pp_in, in_valid, out_ready,
    output in_ready, prod, out_valid
  );
endinterface

// File: rtl/pp_reduce_seq.sv
// Sequential partial-product reducer: one matrix row is shift-added per clock
// into a 2N-bit product, with optional truncation of the low columns.
module pp_reduce_seq #(
  parameter int N           = 6,
  parameter int APPROX_COLS = 0
) (
  input  logic              clk,
  input  logic              rst,
  pp_reduce_seq_if.slave    bus,
  output logic              busy
);
  localparam int CW = $clog2(N) + 1;
  localparam int PW = 2 * N;
  localparam int MW = N * N;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                 state, state_next;
  logic [MW-1:0]          mat;
  logic [PW-1:0]          acc;
  logic [PW-1:0]          prod_r;
  logic [CW-1:0]          cnt;
  logic [N-1:0]           rows [N];
  logic [N-1:0]           row;
  logic [PW-1:0]          term;
  logic [PW-1:0]          acc_sum;
  logic                   last_row;

  // Keep bit j of row r only when its weight 2^(r+j) survives truncation.
  function automatic logic [N-1:0] col_mask(input logic [CW-1:0] r);
    logic [N-1:0] m;
    for (int j = 0; j < N; j++) m[j] = ((int'(r) + j) >= APPROX_COLS);
    return m;
  endfunction

  for (genvar i = 0; i < N; i++) begin : g_rows
    assign rows[i] = mat[i*N +: N];
  end

  always_comb begin
    row      = rows[cnt[CW-2:0]];
    term     = {{N{1'b0}}, row & col_mask(cnt)} << cnt;
    acc_sum  = acc + term;
    last_row = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = ACCUM;
      ACCUM:   if (last_row)      state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mat    <= '0;
      acc    <= '0;
      cnt    <= '0;
      prod_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mat <= bus.pp_in;
            acc <= '0;
            cnt <= '0;
          end
        end
        ACCUM: begin
          acc <= acc_sum;
          cnt <= cnt + CW'(1);
          if (last_row) prod_r <= acc_sum;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.prod      = prod_r;
  assign busy          = (state != IDLE);
endmodule

// File: tb/tb_pp_reduce_seq.sv
// Bench for pp_reduce_seq: an exact instance and an APPROX_COLS=3 instance
// share the same stimulus and are both checked against a reference model.
module tb_pp_reduce_seq;
  localparam int N = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cur_x = 0;
  int   cur_y = 0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic busy0, busy3;
  logic [N*N-1:0] pp;

  int errors = 0;
  int checks = 0;

  pp_reduce_seq_if #(.N(N)) if0 ();
  pp_reduce_seq_if #(.N(N)) if3 ();

  pp_reduce_seq #(.N(N), .APPROX_COLS(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave), .busy(busy0));
  pp_reduce_seq #(.N(N), .APPROX_COLS(3)) dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave), .busy(busy3));

  always #5 clk = ~clk;

  function automatic logic [N*N-1:0] build_pp(input int x, input int y);
    logic [N*N-1:0] m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        m[i*N + j] = x[j] & y[i];
    return m;
  endfunction

  // Product minus every partial-product bit whose weight lies below ac.
  function automatic int model_prod(input int x, input int y, input int ac);
    int p;
    p = x * y;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (x[j] && y[i] && (i + j) < ac) p -= (1 << (i + j));
    return p;
  endfunction

  assign pp            = build_pp(cur_x, cur_y);
  assign if0.pp_in     = pp;
  assign if3.pp_in     = pp;
  assign if0.in_valid  = in_valid;
  assign if3.in_valid  = in_valid;
  assign if0.out_ready = out_ready;
  assign if3.out_ready = out_ready;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Reference: transaction-level timing (N row cycles, then hold until taken).
  int m_rows [2] = '{0, 0};
  bit m_idle [2] = '{1'b1, 1'b1};
  bit m_done [2] = '{1'b0, 1'b0};
  int m_pend [2] = '{0, 0};
  int m_prod [2] = '{0, 0};
  int m_ac   [2] = '{0, 3};

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_rows[k] = 0; m_idle[k] = 1'b1; m_done[k] = 1'b0; m_prod[k] = 0;
      end else if (m_idle[k]) begin
        if (in_valid === 1'b1) begin
          m_pend[k] = model_prod(cur_x, cur_y, m_ac[k]);
          m_rows[k] = N;
          m_idle[k] = 1'b0;
        end
      end else if (m_rows[k] > 0) begin
        m_rows[k]--;
        if (m_rows[k] == 0) begin
          m_done[k] = 1'b1;
          m_prod[k] = m_pend[k];
        end
      end else if (m_done[k] && out_ready === 1'b1) begin
        m_done[k] = 1'b0;
        m_idle[k] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("a0_in_ready",  int'(if0.in_ready),  int'(m_idle[0]));
    chk("a0_out_valid", int'(if0.out_valid), int'(m_done[0]));
    chk("a0_busy",      int'(busy0),         int'(!m_idle[0]));
    chk("a0_prod",      int'(if0.prod),      m_prod[0]);
    chk("a3_in_ready",  int'(if3.in_ready),  int'(m_idle[1]));
    chk("a3_out_valid", int'(if3.out_valid), int'(m_done[1]));
    chk("a3_busy",      int'(busy3),         int'(!m_idle[1]));
    chk("a3_prod",      int'(if3.prod),      m_prod[1]);
  end

  task automatic run_txn(input int x, input int y, input int exp0, input int exp3,
                         input int hold, input bit poke);
    int  n;
    bit  got;
    @(posedge clk); #1;
    cur_x = x; cur_y = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("in_ready_drop", int'(if0.in_ready), 0);
    n = 0; got = 1'b0;
    while (n < 20 && !got) begin
      if (poke && n == 1) begin
        cur_x = 2; cur_y = 2; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (if0.out_valid === 1'b1) got = 1'b1;
    end
    in_valid = 1'b0;
    chk("latency", n, N);
    chk("prod_exact", int'(if0.prod), exp0);
    chk("prod_approx", int'(if3.prod), exp3);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    chk("held_valid", int'(if0.out_valid), 1);
    chk("held_in_ready", int'(if0.in_ready), 0);
    chk("held_prod", int'(if0.prod), exp0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_out_valid", int'(if0.out_valid), 0);
    chk("post_in_ready", int'(if0.in_ready), 1);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_in_ready", int'(if0.in_ready), 1);
    chk("rst_out_valid", int'(if0.out_valid), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_prod", int'(if0.prod), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("model_1x3", model_prod(1, 3, 0), 3);
    chk("model_7x7_a3", model_prod(7, 7, 3), 32);
    chk("model_63x63_a3", model_prod(63, 63, 3), 3952);
    chk("model_full_trunc", model_prod(63, 63, 2*N), 0);

    run_txn(1, 3, 3, 0, 0, 1'b0);
    run_txn(63, 63, 3969, 3952, 0, 1'b0);
    run_txn(0, 0, 0, 0, 0, 1'b0);
    run_txn(7, 7, 49, 32, 10, 1'b0);
    run_txn(5, 9, 45, 40, 0, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    run_txn(2, 2, 4, 0, 0, 1'b0);

    @(posedge clk); #1;
    cur_x = 63; cur_y = 63; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_out_valid", int'(if0.out_valid), 0);
    chk("abort_prod", int'(if0.prod), 0);
    chk("abort_in_ready", int'(if0.in_ready), 1);
    chk("abort_prod_a3", int'(if3.prod), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("no_stale_valid", int'(if0.out_valid), 0);
    chk("no_stale_prod", int'(if0.prod), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
